// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: ROM request/response, instruction handshake and redirect.
// The master side is the fetch unit; the slave side is its environment.
interface fetch_if;
  logic        rom_rd;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_word;
  logic        instr_len;
  logic [15:0] instr_pc;
  logic        jump;
  logic [15:0] jump_target;

  modport master (
    output rom_rd, rom_addr, instr_valid, instr_word, instr_len, instr_pc,
    input  rom_data, instr_ready, jump, jump_target
  );

  modport slave (
    input  rom_rd, rom_addr, instr_valid, instr_word, instr_len, instr_pc,
    output rom_data, instr_ready, jump, jump_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Byte-wide instruction prefetcher: one-cycle-latency ROM reads into a tagged
// circular queue, assembling 1- or 2-byte instructions (first byte bit7 = long).
module fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic   clk,
  input  logic   rst_n,
  fetch_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [15:0]   fp_reg;
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          inflight_reg;
  logic [15:0]   inflight_addr_reg;

  logic [7:0]  data_mem [FIFO_DEPTH];
  logic [15:0] tag_mem  [FIFO_DEPTH];

  logic [7:0]    head_byte;
  logic [AW-1:0] next_ptr;
  logic          head_long;
  logic          xfer;
  logic          push;
  logic [CW-1:0] pop_n;
  logic [CW:0]   level;

  assign head_byte = data_mem[rd_ptr_reg];
  assign next_ptr  = rd_ptr_reg + AW'(1);
  assign head_long = head_byte[7];

  assign bus.instr_valid = !bus.jump &&
                           (head_long ? (count_reg >= CW'(2)) : (count_reg >= CW'(1)));
  assign bus.instr_word  = {head_byte, head_long ? data_mem[next_ptr] : 8'h00};
  assign bus.instr_len   = head_long;
  assign bus.instr_pc    = tag_mem[rd_ptr_reg];

  assign xfer  = bus.instr_valid && bus.instr_ready;
  assign pop_n = xfer ? (head_long ? CW'(2) : CW'(1)) : CW'(0);

  // Credit check counts the byte still in flight and frees what pops this cycle.
  assign level = {1'b0, count_reg} + (CW+1)'(inflight_reg) - {1'b0, pop_n};

  // rst_n gating keeps the request line quiet while reset is held.
  assign bus.rom_rd   = rst_n && !bus.jump && (level < DEPTH_L);
  assign bus.rom_addr = fp_reg;

  // A redirect in the return cycle drops the arriving byte.
  assign push = inflight_reg && !bus.jump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp_reg            <= RESET_PC;
      rd_ptr_reg        <= '0;
      wr_ptr_reg        <= '0;
      count_reg         <= '0;
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= RESET_PC;
    end else if (bus.jump) begin
      fp_reg       <= bus.jump_target;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
    end else begin
      if (bus.rom_rd) fp_reg <= fp_reg + 16'd1;
      inflight_reg      <= bus.rom_rd;
      inflight_addr_reg <= fp_reg;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_reg + pop_n[AW-1:0];
      count_reg  <= count_reg + CW'(push) - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= bus.rom_data;
      tag_mem[wr_ptr_reg]  <= inflight_addr_reg;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural ROM with one-cycle latency and
// hand-computed expectations per cycle.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   rd_count;

  fetch_if bus ();
  fetch_unit #(.FIFO_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:65535];
  always @(posedge clk) if (bus.rom_rd) bus.rom_data <= rom[bus.rom_addr];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench in cycle 0 after release, inputs settled.
  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    bus.rom_data = 8'h00; bus.instr_ready = 1'b0;
    bus.jump = 1'b0; bus.jump_target = 16'h0000;

    // ---- reset state and basic one-byte stream
    rom[0] = 8'h16; rom[1] = 8'h11; rom[2] = 8'h12; rom[3] = 8'h00;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_rom_rd", 16'(bus.rom_rd), 16'h0);
    chk("rst_valid", 16'(bus.instr_valid), 16'h0);
    chk("rst_addr", bus.rom_addr, 16'h0000);
    tick(); rst_n = 1'b1; bus.instr_ready = 1'b1; #1;
    chk("c0_rom_rd", 16'(bus.rom_rd), 16'h1);
    chk("c0_addr", bus.rom_addr, 16'h0000);
    tick(); #1;
    chk("c1_valid", 16'(bus.instr_valid), 16'h0);
    chk("c1_addr", bus.rom_addr, 16'h0001);
    tick(); #1;
    chk("s1_word0", bus.instr_word, 16'h1600); chk("s1_pc0", bus.instr_pc, 16'h0000);
    tick(); #1;
    chk("s1_word1", bus.instr_word, 16'h1100); chk("s1_pc1", bus.instr_pc, 16'h0001);
    tick(); #1;
    chk("s1_word2", bus.instr_word, 16'h1200); chk("s1_pc2", bus.instr_pc, 16'h0002);
    tick(); #1;
    chk("s1_word3", bus.instr_word, 16'h0000); chk("s1_pc3", bus.instr_pc, 16'h0003);
    chk("s1_valid3", 16'(bus.instr_valid), 16'h1);

    // ---- two-byte instruction then one-byte
    rom[0] = 8'h85; rom[1] = 8'h3C; rom[2] = 8'h10;
    reset_pulse();
    tick(); tick(); #1;
    chk("s2_wait_2nd", 16'(bus.instr_valid), 16'h0);
    tick(); #1;
    chk("s2_valid", 16'(bus.instr_valid), 16'h1);
    chk("s2_word", bus.instr_word, 16'h853C);
    chk("s2_len", 16'(bus.instr_len), 16'h1);
    chk("s2_pc", bus.instr_pc, 16'h0000);
    tick(); #1;
    chk("s2_word_b", bus.instr_word, 16'h1000);
    chk("s2_len_b", 16'(bus.instr_len), 16'h0);
    chk("s2_pc_b", bus.instr_pc, 16'h0002);

    // ---- back-pressure: queue fills, then drains in order
    for (int i = 0; i < 8; i++) rom[i] = 8'(i + 1);
    bus.instr_ready = 1'b0;
    reset_pulse();
    rd_count = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.rom_rd) rd_count++;
      if (c == 5 || c == 9) begin
        chk("s3_hold_word", bus.instr_word, 16'h0100);
        chk("s3_hold_pc", bus.instr_pc, 16'h0000);
      end
      tick(); #1;
    end
    chk("s3_req_count", 16'(rd_count), 16'd4);
    bus.instr_ready = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      chk("s3_valid", 16'(bus.instr_valid), 16'h1);
      chk("s3_word", bus.instr_word, {8'(i + 1), 8'h00});
      chk("s3_pc", bus.instr_pc, 16'(i));
      tick(); #1;
    end

    // ---- redirect with a byte in flight, then back-to-back redirects
    rom[16'h0040] = 8'h22; rom[16'h0041] = 8'h23; rom[16'h0080] = 8'h33;
    bus.instr_ready = 1'b0;
    reset_pulse();
    tick(); tick();
    bus.jump = 1'b1; bus.jump_target = 16'h0040; #1;
    chk("s4_jump_valid", 16'(bus.instr_valid), 16'h0);
    chk("s4_jump_rd", 16'(bus.rom_rd), 16'h0);
    tick(); bus.jump = 1'b0; bus.instr_ready = 1'b1; #1;
    chk("s4_rd_after", 16'(bus.rom_rd), 16'h1);
    chk("s4_addr_after", bus.rom_addr, 16'h0040);
    chk("s4_empty", 16'(bus.instr_valid), 16'h0);
    tick(); #1;
    chk("s4_not_yet", 16'(bus.instr_valid), 16'h0);
    tick(); #1;
    chk("s4_word", bus.instr_word, 16'h2200); chk("s4_pc", bus.instr_pc, 16'h0040);
    tick(); #1;
    chk("s4_word_b", bus.instr_word, 16'h2300); chk("s4_pc_b", bus.instr_pc, 16'h0041);
    tick(); bus.jump = 1'b1; bus.jump_target = 16'h0080; #1;
    tick(); bus.jump_target = 16'h0040; #1;
    tick(); bus.jump = 1'b0; #1;
    chk("s4_dbl_addr", bus.rom_addr, 16'h0040);
    tick(); tick(); #1;
    chk("s4_dbl_word", bus.instr_word, 16'h2200); chk("s4_dbl_pc", bus.instr_pc, 16'h0040);

    // ---- two-byte instruction spanning the address wrap
    rom[16'hFFFE] = 8'h11; rom[16'hFFFF] = 8'h9A; rom[0] = 8'h55;
    bus.instr_ready = 1'b1;
    reset_pulse();
    bus.jump = 1'b1; bus.jump_target = 16'hFFFE; #1;
    tick(); bus.jump = 1'b0; #1;
    chk("s5_addr_fffe", bus.rom_addr, 16'hFFFE);
    tick(); #1;
    chk("s5_addr_ffff", bus.rom_addr, 16'hFFFF);
    tick(); #1;
    chk("s5_addr_0000", bus.rom_addr, 16'h0000);
    chk("s5_word_a", bus.instr_word, 16'h1100); chk("s5_pc_a", bus.instr_pc, 16'hFFFE);
    tick(); #1;
    chk("s5_addr_0001", bus.rom_addr, 16'h0001);
    chk("s5_wait_2nd", 16'(bus.instr_valid), 16'h0);
    tick(); #1;
    chk("s5_valid", 16'(bus.instr_valid), 16'h1);
    chk("s5_word", bus.instr_word, 16'h9A55);
    chk("s5_len", 16'(bus.instr_len), 16'h1);
    chk("s5_pc", bus.instr_pc, 16'hFFFF);

    // ---- reset mid-stream with the queue full
    bus.instr_ready = 1'b0;
    reset_pulse();
    for (int c = 0; c < 8; c++) tick();
    #1;
    chk("s6_full_valid", 16'(bus.instr_valid), 16'h1);
    chk("s6_full_rd", 16'(bus.rom_rd), 16'h0);
    rst_n = 1'b0; #1;
    chk("s6_abort_valid", 16'(bus.instr_valid), 16'h0);
    chk("s6_abort_rd", 16'(bus.rom_rd), 16'h0);
    chk("s6_abort_addr", bus.rom_addr, 16'h0000);
    tick(); rst_n = 1'b1; bus.instr_ready = 1'b1; #1;
    chk("s6_c0_rd", 16'(bus.rom_rd), 16'h1);
    chk("s6_c0_addr", bus.rom_addr, 16'h0000);
    tick(); #1;
    chk("s6_c1_valid", 16'(bus.instr_valid), 16'h0);
    tick(); #1;
    chk("s6_c2_valid", 16'(bus.instr_valid), 16'h1);
    chk("s6_c2_word", bus.instr_word, 16'h5500);
    chk("s6_c2_pc", bus.instr_pc, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
